// File: rtl/alu_share_ctrl_pkg.sv
// alu_share_ctrl_pkg
//   Shared definitions for the ALU sharing controller: datapath width,
//   ALU control codes, FSM state encodings and a helper that tells the
//   controller whether a control code is one the ALU implements.
package alu_share_ctrl_pkg;

    localparam int DATA_W = 32;

    // ALU control codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_MUL = 4'b0111;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    function automatic logic ctrl_supported(input logic [3:0] ctrl);
        case (ctrl)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_MUL: return 1'b1;
            default:                                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_share_ctrl_alu.sv
// alu_share_ctrl_alu
//   Combinational 32-bit ALU shared by both requesters.
//   Ports:
//     data1, data2 : signed operands
//     ctrl         : ALU control code (see alu_share_ctrl_pkg)
//     result       : operation result, modulo 2^32 (mul returns low word)
//     zero         : result == 0
module alu_share_ctrl_alu
    import alu_share_ctrl_pkg::*;
(
    input  logic signed [DATA_W-1:0] data1,
    input  logic signed [DATA_W-1:0] data2,
    input  logic        [3:0]        ctrl,
    output logic signed [DATA_W-1:0] result,
    output logic                     zero
);

    always_comb begin
        result = '0;
        case (ctrl)
            ALU_AND: result = data1 & data2;
            ALU_OR:  result = data1 | data2;
            ALU_ADD: result = data1 + data2;
            ALU_SUB: result = data1 - data2;
            // Low word of the product is identical for signed and unsigned.
            ALU_MUL: result = data1 * data2;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl
//   Shares one ALU between two requesters. Round-robin arbitration in IDLE,
//   operands latched on grant, multi-cycle execute window for multiply,
//   result returned through a valid/ready channel tagged with requester ID.
//   Ports:
//     clk_i, rst_i              : clock, asynchronous active-low reset
//     reqN_valid_i/reqN_ready_o : request handshake for requester N (0/1)
//     reqN_data1_i/data2_i      : requester N operands
//     reqN_ctrl_i               : requester N ALU control code
//     rsp_valid_o/rsp_ready_i   : response handshake
//     rsp_data_o, rsp_zero_o    : result and result==0 flag
//     rsp_id_o                  : requester that issued the result
//     busy_o                    : controller not in IDLE
module alu_share_ctrl
    import alu_share_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [DATA_W-1:0] req0_data1_i,
    input  logic [DATA_W-1:0] req0_data2_i,
    input  logic [3:0]        req0_ctrl_i,
    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [DATA_W-1:0] req1_data1_i,
    input  logic [DATA_W-1:0] req1_data2_i,
    input  logic [3:0]        req1_ctrl_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              rsp_zero_o,
    output logic              rsp_id_o,
    output logic              busy_o
);

    logic [1:0]               state;
    logic                     prio;
    logic [3:0]               cnt;
    logic                     id_q;
    logic signed [DATA_W-1:0] op1_q;
    logic signed [DATA_W-1:0] op2_q;
    logic [3:0]               ctrl_q;
    logic [DATA_W-1:0]        rsp_data_q;
    logic                     rsp_zero_q;

    logic                     grant0;
    logic                     grant1;
    logic [DATA_W-1:0]        sel_data1;
    logic [DATA_W-1:0]        sel_data2;
    logic [3:0]               sel_ctrl;
    logic signed [DATA_W-1:0] alu_result;
    logic                     alu_zero;

    // Arbitration: prio breaks the tie only when both requesters are valid.
    assign grant0 = (state == ST_IDLE) && req0_valid_i && (!prio || !req1_valid_i);
    assign grant1 = (state == ST_IDLE) && req1_valid_i && ( prio || !req0_valid_i);

    assign req0_ready_o = grant0;
    assign req1_ready_o = grant1;

    assign sel_data1 = grant1 ? req1_data1_i : req0_data1_i;
    assign sel_data2 = grant1 ? req1_data2_i : req0_data2_i;
    assign sel_ctrl  = grant1 ? req1_ctrl_i  : req0_ctrl_i;

    // Operand registers are pure data; they only matter after a grant loads them.
    always_ff @(posedge clk_i) begin
        if (grant0 || grant1) begin
            op1_q  <= sel_data1;
            op2_q  <= sel_data2;
            ctrl_q <= sel_ctrl;
        end
    end

    // The ALU only ever sees latched operands, never the request ports.
    alu_share_ctrl_alu u_alu (
        .data1  (op1_q),
        .data2  (op2_q),
        .ctrl   (ctrl_q),
        .result (alu_result),
        .zero   (alu_zero)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= ST_IDLE;
            prio       <= 1'b0;
            cnt        <= '0;
            id_q       <= 1'b0;
            rsp_data_q <= '0;
            rsp_zero_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant0 || grant1) begin
                        state <= ST_EXEC;
                        id_q  <= grant1;
                        cnt   <= (sel_ctrl == ALU_MUL) ? 4'(MUL_LAT - 1) : 4'd0;
                    end
                end
                ST_EXEC: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= ST_RESP;
                        // Unsupported codes return a forced zero instead of
                        // whatever the ALU happens to output.
                        if (ctrl_supported(ctrl_q)) begin
                            rsp_data_q <= alu_result;
                            rsp_zero_q <= alu_zero;
                        end else begin
                            rsp_data_q <= '0;
                            rsp_zero_q <= 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        state <= ST_IDLE;
                        prio  <= ~id_q;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign rsp_valid_o = (state == ST_RESP);
    assign rsp_data_o  = rsp_data_q;
    assign rsp_zero_o  = rsp_zero_q;
    assign rsp_id_o    = id_q;
    assign busy_o      = (state != ST_IDLE);

endmodule
